fir_decim_requant: RTL and testbench
====================================

// Module: fir_decim_requant
// PURPOSE
//   Receiving end of the FIR output stream. Takes the 16-bit signed filter output,
//   integrate-and-dumps it over DECIM samples, rounds and saturates the sum to 8-bit signed,
//   and buffers the results in a small FIFO with a valid/ready output handshake.
//   Sits directly after the fir block; the FIR cannot stall, so overflow drops samples and flags it.
// PARAMETERS
//   DECIM       4   decimation ratio, input samples per output sample (>=2)
//   SHIFT       2   arithmetic right shift applied to the block sum before saturation (0..8)
//   FIFO_DEPTH  4   output FIFO entries (power of 2, >=2)
// PORTS
//   clk          in   1   single clock; all state updates on posedge
//   reset        in   1   asynchronous, active-high; clears all state immediately
//   din          in   16  signed FIR output sample
//   din_valid    in   1   din is a new sample this cycle
//   dout         out  8   signed requantised sample at FIFO head
//   dout_valid   out  1   FIFO not empty
//   dout_ready   in   1   consumer accepts dout this cycle
//   fill         out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
//   sat_pulse    out  1   1-cycle pulse: the pushed result was saturated
//   drop_sticky  out  1   a result was lost to a full FIFO; held until reset
// BEHAVIOUR
//   Reset (async): acc=0, phase=0, FIFO empty; dout=0, dout_valid=0, fill=0, sat_pulse=0, drop_sticky=0.
//   Accumulator: ACC_W = 16+$clog2(DECIM), signed, sign-extended din; no overflow is possible.
//   Each cycle with din_valid=1:
//     phase<DECIM-1: acc<=acc+din, phase<=phase+1.
//     phase==DECIM-1: sum=acc+din; acc<=0; phase<=0; the result is pushed this edge.
//   din_valid=0: acc and phase hold; gaps of any length are allowed.
//   Requant: SHIFT>0: r=(sum + 2^(SHIFT-1)) >>> SHIFT (round half toward +inf); SHIFT=0: r=sum.
//     r>127 -> 127; r<-128 -> -128; either case raises sat_pulse in the push cycle (registered, 1 clk).
//   FIFO: push and pop on the same edge. Pop when dout_valid & dout_ready.
//     Empty: a pushed value shows on dout with dout_valid=1 the cycle after the push edge (latency 1).
//     Full with no pop: push discarded, FIFO unchanged, drop_sticky<=1; sat_pulse still reports.
//     Full with pop on the same edge: push accepted, fill unchanged.
//     Empty with pop: impossible (dout_valid=0), so no pop.
//   dout holds the head value while dout_valid=1 and dout_ready=0 (stable under backpressure).
//   When empty, dout holds its last value (0 after reset). Output order matches push order.
//   Pointers wrap modulo FIFO_DEPTH; fill counts 0..FIFO_DEPTH inclusive.
//   Reset mid-block discards the partial accumulation and all FIFO contents.
//   The next block starts fresh at phase 0 after reset is deasserted.
// TESTING (DECIM=4, SHIFT=2, FIFO_DEPTH=4, dout_ready=1 unless stated)
//   1. din 10,20,30,40 on consecutive valids -> sum 100, dout=25, dout_valid 1 cycle after 4th sample.
//   2. din -3 x4 -> sum -12, (-12+2)>>>2 = -3 -> dout=-3 (0xFD), sat_pulse=0.
//   3. din 1000 x4 -> dout=127, sat_pulse=1 for one cycle; din -1000 x4 -> dout=-128, sat_pulse=1.
//   4. dout_ready=0, 5 blocks of 4,8,12,16,20 x4 -> fill=4, 5th dropped, drop_sticky=1;
//      then dout_ready=1 -> dout 4,8,12,16 in order, then dout_valid=0.
//   5. din_valid toggled 1,0,0,1,0,1,1 with din=4 on valid cycles -> one output, 4, after 4th valid.
//   6. 2 samples of 100, assert reset 1 cycle, then 8 x4 -> single output 8, no residue of 100.

Source files
------------

// File: rtl/fir_decim_requant.sv
// Integrate-and-dump decimator for the FIR output stream. It sums DECIM input samples,
// rounds and saturates the sum to 8-bit signed, and queues the results in a small FIFO
// with a valid/ready output. The FIR upstream cannot stall, so a result that arrives
// while the FIFO is full is dropped and the loss is latched in drop_sticky_o.
module fir_decim_requant #(
  parameter int unsigned DECIM      = 4,
  parameter int unsigned SHIFT      = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic signed [15:0]            din_i,
  input  logic                          din_valid_i,
  output logic signed [7:0]             dout_o,
  output logic                          dout_valid_o,
  input  logic                          dout_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   fill_o,
  output logic                          sat_pulse_o,
  output logic                          drop_sticky_o
);

  localparam int unsigned AccW = 16 + $clog2(DECIM);
  localparam int unsigned PhW  = $clog2(DECIM);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  // One extra bit so adding the rounding constant can never wrap the block sum
  localparam int unsigned RndW = AccW + 1;
  localparam int          RndInt = (SHIFT == 0) ? 0 : (1 << (SHIFT - 1));

  logic signed [AccW-1:0] acc_q, acc_d, din_ext, sum;
  logic        [PhW-1:0]  phase_q, phase_d;
  logic signed [RndW-1:0] rnd_sum, shifted;
  logic signed [7:0]      res;
  logic                   block_end, push, pop, full, empty, push_ok, sat_hi, sat_lo;

  logic signed [7:0]      mem_q [FIFO_DEPTH];
  logic        [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic        [CntW-1:0] fill_q, fill_d;
  logic signed [7:0]      last_q;
  logic                   sat_q, drop_q;

  // Block sum, rounding shift and saturation to 8 bits
  always_comb begin
    din_ext   = {{(AccW-16){din_i[15]}}, din_i};
    sum       = acc_q + din_ext;
    block_end = (phase_q == PhW'(DECIM - 1));
    push      = din_valid_i && block_end;
    rnd_sum   = $signed({sum[AccW-1], sum}) + $signed(RndW'(RndInt));
    shifted   = rnd_sum >>> SHIFT;
    sat_hi    = shifted > $signed(RndW'(127));
    sat_lo    = shifted < -$signed(RndW'(128));
    if (sat_hi)      res = 8'sd127;
    else if (sat_lo) res = -8'sd128;
    else             res = shifted[7:0];
  end

  // Accumulator and phase next state; both hold across gaps in din_valid_i
  always_comb begin
    acc_d   = acc_q;
    phase_d = phase_q;
    if (din_valid_i) begin
      if (block_end) begin
        acc_d   = '0;
        phase_d = '0;
      end else begin
        acc_d   = sum;
        phase_d = phase_q + PhW'(1);
      end
    end
  end

  // FIFO control; a pop frees the slot a same-edge push into a full FIFO needs
  always_comb begin
    empty   = (fill_q == '0);
    full    = (fill_q == CntW'(FIFO_DEPTH));
    pop     = !empty && dout_ready_i;
    push_ok = push && (!full || pop);
    fill_d  = fill_q;
    if (push_ok && !pop)      fill_d = fill_q + CntW'(1);
    else if (!push_ok && pop) fill_d = fill_q - CntW'(1);
  end

  // Accumulator, phase and status flags
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q   <= '0;
      phase_q <= '0;
      sat_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      phase_q <= phase_d;
      sat_q   <= push && (sat_hi || sat_lo);
      if (push && !push_ok) drop_q <= 1'b1;
    end
  end

  // FIFO storage, pointers, occupancy and the last popped value
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      last_q   <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= res;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        last_q   <= mem_q[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      fill_q <= fill_d;
    end
  end

  // Head of FIFO when non-empty, otherwise the last value handed out
  always_comb begin
    dout_o        = empty ? last_q : mem_q[rd_ptr_q];
    dout_valid_o  = !empty;
    fill_o        = fill_q;
    sat_pulse_o   = sat_q;
    drop_sticky_o = drop_q;
  end

endmodule

// File: tb/tb_fir_decim_requant.sv
// Bench for fir_decim_requant: directed block table, hand-written corner sequences and
// a randomized run, all checked every cycle against a queue-based behavioural model.
module tb_fir_decim_requant;

  localparam int DECIM      = 4;
  localparam int SHIFT      = 2;
  localparam int FIFO_DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic signed [15:0] din;
  logic              din_valid;
  logic signed [7:0] dout;
  logic              dout_valid;
  logic              dout_ready;
  logic [2:0]        fill;
  logic              sat_pulse;
  logic              drop_sticky;

  fir_decim_requant #(
    .DECIM      (DECIM),
    .SHIFT      (SHIFT),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .din_i         (din),
    .din_valid_i   (din_valid),
    .dout_o        (dout),
    .dout_valid_o  (dout_valid),
    .dout_ready_i  (dout_ready),
    .fill_o        (fill),
    .sat_pulse_o   (sat_pulse),
    .drop_sticky_o (drop_sticky)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  int m_acc, m_cnt, m_last;
  int q[$];
  bit m_sat, m_drop;

  typedef struct {
    int s0, s1, s2, s3;
    int exp;
    bit exp_sat;
  } blk_t;
  blk_t tbl[5];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Rounded, shifted block sum as a plain floor division (before clamping)
  function automatic int rq_raw(input int s);
    int d, num, r;
    d   = 1 << SHIFT;
    num = s + ((SHIFT > 0) ? d / 2 : 0);
    r   = num / d;
    if ((num % d) != 0 && num < 0) r = r - 1;
    return r;
  endfunction

  function automatic int clamp8(input int r);
    if (r > 127)  return 127;
    if (r < -128) return -128;
    return r;
  endfunction

  task automatic model_clear();
    m_acc = 0; m_cnt = 0; m_last = 0; m_sat = 0; m_drop = 0;
    q.delete();
  endtask

  task automatic check_all();
    chk("dout_valid", int'(dout_valid), (q.size() > 0) ? 1 : 0);
    chk("fill", int'(fill), q.size());
    chk("dout", int'(dout), (q.size() > 0) ? q[0] : m_last);
    chk("sat_pulse", int'(sat_pulse), int'(m_sat));
    chk("drop_sticky", int'(drop_sticky), int'(m_drop));
  endtask

  // One clock: drive at negedge, update model after posedge, check, return at negedge
  task automatic step(input int d, input bit v, input bit r);
    bit pop_m, push_m;
    int raw;
    din        = 16'(d);
    din_valid  = v;
    dout_ready = r;
    pop_m  = (q.size() > 0) && r;
    push_m = v && (m_cnt == DECIM - 1);
    raw    = push_m ? rq_raw(m_acc + d) : 0;
    @(posedge clk);
    #1;
    if (pop_m) m_last = q.pop_front();
    m_sat = push_m && (raw > 127 || raw < -128);
    if (push_m) begin
      if (q.size() < FIFO_DEPTH) q.push_back(clamp8(raw));
      else m_drop = 1;
    end
    if (v) begin
      if (m_cnt == DECIM - 1) begin
        m_acc = 0;
        m_cnt = 0;
      end else begin
        m_acc += d;
        m_cnt++;
      end
    end
    check_all();
    @(negedge clk);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge
  task automatic apply_reset();
    din_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    model_clear();
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    tbl[0] = '{s0: 10,    s1: 20,    s2: 30,    s3: 40,    exp: 25,   exp_sat: 1'b0};
    tbl[1] = '{s0: -3,    s1: -3,    s2: -3,    s3: -3,    exp: -3,   exp_sat: 1'b0};
    tbl[2] = '{s0: 1000,  s1: 1000,  s2: 1000,  s3: 1000,  exp: 127,  exp_sat: 1'b1};
    tbl[3] = '{s0: -1000, s1: -1000, s2: -1000, s3: -1000, exp: -128, exp_sat: 1'b1};
    tbl[4] = '{s0: 130,   s1: 130,   s2: 130,   s3: 122,   exp: 128 > 127 ? 127 : 0,
               exp_sat: 1'b1};

    rst = 1'b1; din = '0; din_valid = 1'b0; dout_ready = 1'b1;
    model_clear();
    #1;
    check_all();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed blocks with fixed expected results
    foreach (tbl[i]) begin
      step(tbl[i].s0, 1'b1, 1'b1);
      step(tbl[i].s1, 1'b1, 1'b1);
      step(tbl[i].s2, 1'b1, 1'b1);
      step(tbl[i].s3, 1'b1, 1'b1);
      chk("tbl_valid", int'(dout_valid), 1);
      chk("tbl_dout", int'(dout), tbl[i].exp);
      chk("tbl_sat", int'(sat_pulse), int'(tbl[i].exp_sat));
      step(0, 1'b0, 1'b1);
      chk("tbl_sat_clear", int'(sat_pulse), 0);
    end

    // Backpressure: five blocks into a four-entry FIFO, then drain in order
    for (int b = 1; b <= 5; b++)
      for (int k = 0; k < 4; k++) step(4 * b, 1'b1, 1'b0);
    chk("bp_fill", int'(fill), 4);
    chk("bp_drop", int'(drop_sticky), 1);
    for (int i = 0; i < 4; i++) begin
      chk("bp_order", int'(dout), 4 * (i + 1));
      step(0, 1'b0, 1'b1);
    end
    chk("bp_empty", int'(dout_valid), 0);
    chk("bp_hold", int'(dout), 16);
    chk("bp_drop_held", int'(drop_sticky), 1);

    // Gaps in din_valid
    apply_reset();
    step(4, 1'b1, 1'b1); step(4, 1'b0, 1'b1); step(4, 1'b0, 1'b1);
    step(4, 1'b1, 1'b1); step(4, 1'b0, 1'b1); step(4, 1'b1, 1'b1);
    chk("gap_none_yet", int'(dout_valid), 0);
    step(4, 1'b1, 1'b1);
    chk("gap_valid", int'(dout_valid), 1);
    chk("gap_dout", int'(dout), 4);
    step(0, 1'b0, 1'b1);

    // Reset mid-block with a queued result discards both
    for (int k = 0; k < 4; k++) step(40, 1'b1, 1'b0);
    step(100, 1'b1, 1'b0);
    step(100, 1'b1, 1'b0);
    apply_reset();
    chk("rst_fill", int'(fill), 0);
    chk("rst_dout", int'(dout), 0);
    for (int k = 0; k < 4; k++) step(8, 1'b1, 1'b1);
    chk("rst_fresh_dout", int'(dout), 8);
    chk("rst_fresh_fill", int'(fill), 1);
    step(0, 1'b0, 1'b1);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      int d;
      bit v, r;
      if ($urandom_range(0, 699) == 0) apply_reset();
      d = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 65535)) - 32768
                                       : int'($urandom_range(0, 400)) - 200;
      v = ($urandom_range(0, 3) != 0);
      r = (n % 200 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      step(d, v, r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
